interpolate: RTL and testbench

//   Integer-factor upsampler; the transmit-side counterpart of the decimator. Accepts low-rate

---
 rtl/interp_pkg.sv | 14 +
 rtl/interp_lerp.sv | 47 ++++
 rtl/interpolate.sv | 115 +++++++++++
 tb/tb_interpolate.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - mode encodings and FSM state type for the interpolator
package interp_pkg;

    localparam logic [1:0] MODE_ZERO = 2'd0;
    localparam logic [1:0] MODE_HOLD = 2'd1;
    localparam logic [1:0] MODE_LIN  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PRIMED = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/interp_lerp.sv
// rtl/interp_lerp.sv - registered output stage: p + k*(x-p)>>>LOG2_RATE or a bypass value
module interp_lerp #(
    parameter int W         = 16,
    parameter int LOG2_RATE = 1,
    parameter int PW        = (LOG2_RATE > 0) ? LOG2_RATE : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          lin_i,
    input  logic [PW-1:0] k_i,
    input  logic [W-1:0]  p_i,
    input  logic [W-1:0]  x_i,
    input  logic [W-1:0]  alt_i,
    output logic [W-1:0]  y_o
);

    logic signed [W:0]    diff;
    logic signed [W+PW:0] diff_x;
    logic signed [W+PW:0] k_x;
    logic signed [W+PW:0] prod;
    logic [W-1:0]         lin;
    logic [W-1:0]         y_d;
    logic [W-1:0]         y_q;

    // The product stays inside W+PW+1 bits, and after the floor shift the sum lies
    // between p and x, so truncating to W bits never wraps.
    always_comb begin
        diff   = {x_i[W-1], x_i} - {p_i[W-1], p_i};
        diff_x = {{PW{diff[W]}}, diff};
        k_x    = {{(W+1){1'b0}}, k_i};
        prod   = diff_x * k_x;
        lin    = p_i + W'(prod >>> LOG2_RATE);
        y_d    = lin_i ? lin : alt_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            y_q <= '0;
        end else if (en_i) begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/interpolate.sv
// rtl/interpolate.sv - integer-factor upsampler: zero-stuff, hold or linear interpolation
module interpolate
    import interp_pkg::*;
#(
    parameter int W         = 16,
    parameter int LOG2_RATE = 1
) (
    input  logic         in_clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] low_in,
    output logic [W-1:0] high_out,
    output logic         valid
);

    localparam int            PW   = (LOG2_RATE > 0) ? LOG2_RATE : 1;
    localparam logic [PW-1:0] LAST = PW'((1 << LOG2_RATE) - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [W-1:0]  prev_q, prev_d;
    logic [W-1:0]  cur_q, cur_d;
    logic [1:0]    mode_q, mode_d;
    logic          valid_q, valid_d;
    logic          last;
    logic          accept;
    logic [W-1:0]  alt;

    assign last     = (phase_q == LAST);
    assign in_ready = (state_q != ST_RUN) | last;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        mode_d  = mode_q;
        valid_d = (state_q == ST_RUN);
        if (accept) begin
            prev_d = cur_q;
            cur_d  = low_in;
            mode_d = mode;
        end
        case (state_q)
            ST_EMPTY: begin
                // Linear needs two samples before the first ramp can start.
                if (accept) begin
                    state_d = (mode == MODE_LIN) ? ST_PRIMED : ST_RUN;
                    phase_d = '0;
                end
            end
            ST_PRIMED: begin
                if (accept) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_d = accept ? ST_RUN : ST_PRIMED;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_EMPTY;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            phase_q <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            mode_q  <= MODE_ZERO;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    // Reserved mode 3 falls through to hold.
    assign alt = ((mode_q == MODE_ZERO) && (phase_q != '0)) ? '0 : cur_q;

    interp_lerp #(
        .W         (W),
        .LOG2_RATE (LOG2_RATE),
        .PW        (PW)
    ) u_lerp (
        .clk_i  (in_clk),
        .rst_ni (rst_n),
        .en_i   (state_q == ST_RUN),
        .lin_i  (mode_q == MODE_LIN),
        .k_i    (phase_q),
        .p_i    (prev_q),
        .x_i    (cur_q),
        .alt_i  (alt),
        .y_o    (high_out)
    );

    assign valid = valid_q;

endmodule

// File: tb/tb_interpolate.sv
// tb/tb_interpolate.sv - directed scoreboard bench for interpolate (W=16, LOG2_RATE=2)
module tb_interpolate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] low_in = '0;
    logic [15:0] high_out;
    logic        valid;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int run_len = 0;
    int last_run = 0;

    interpolate #(.W(16), .LOG2_RATE(2)) dut (
        .in_clk   (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .low_in   (low_in),
        .high_out (high_out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int out_val();
        return int'($signed(high_out));
    endfunction

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            run_len++;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected_valid: got %0d expected none", out_val());
            end
            if (exp_q.size() != 0) chk("sb_sample", out_val(), exp_q.pop_front());
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    task automatic push4(input int a, input int b, input int c, input int d);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    endtask

    task automatic send(input logic [1:0] m, input int x);
        int n;
        n = 0;
        mode     = m;
        low_in   = 16'(x);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_timeout", int'(n < 20), 1);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drain(input int held);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(n < 60), 1);
        @(negedge clk);
        chk("idle_valid", int'(valid), 0);
        chk("idle_ready", int'(in_ready), 1);
        chk("idle_held", out_val(), held);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", int'(valid), 0);
        chk("rst_high_out", out_val(), 0);
        chk("rst_ready", int'(in_ready), 1);

        // linear ramp: first sample only primes
        send(2'd2, 0);
        chk("lin_prime_valid", int'(valid), 0);
        chk("lin_prime_ready", int'(in_ready), 1);
        push4(0, 25, 50, 75);
        send(2'd2, 100);
        idle(0);
        drain(75);

        // gapless linear from held cur=100, then full-scale swing
        push4(100, 8266, 16433, 24600);
        push4(32767, 16383, -1, -16385);
        send(2'd2, 32767);
        send(2'd2, -32768);
        idle(0);
        drain(-16385);
        @(negedge clk);
        chk("extreme_run_len", last_run, 8);

        // hold
        push4(7, 7, 7, 7);
        send(2'd1, 7);
        idle(0);
        drain(7);

        // zero-stuff with in_ready profile and a mid-segment mode change
        push4(7, 0, 0, 0);
        send(2'd0, 7);
        idle(0);
        mode = 2'd2;
        for (int k = 0; k < 3; k++) begin
            chk("zero_ready_low", int'(in_ready), 0);
            @(negedge clk);
        end
        chk("zero_ready_last", int'(in_ready), 1);
        drain(0);

        // reserved mode behaves as hold
        push4(-5, -5, -5, -5);
        send(2'd3, -5);
        idle(0);
        drain(-5);

        // starvation then resume linear from held cur=-5
        idle(6);
        chk("starve_valid", int'(valid), 0);
        chk("starve_held", out_val(), -5);
        push4(-5, -3, -1, 1);
        send(2'd2, 3);
        idle(0);
        drain(1);

        // back-to-back from reset with in_valid held
        do_reset();
        push4(0, 25, 50, 75);
        push4(100, 125, 150, 175);
        send(2'd2, 0);
        send(2'd2, 100);
        send(2'd2, 200);
        idle(0);
        drain(175);
        @(negedge clk);
        chk("b2b_run_len", last_run, 8);

        // reset during phase 1 truncates the segment
        exp_q.push_back(9);
        send(2'd1, 9);
        idle(0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_high_out", out_val(), 0);
        chk("midrst_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        idle(8);
        chk("midrst_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
